// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU operation codes, operand and
// redirect selects, divider state, and the operand forwarding rule.
package ex_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_PASSB  = 5'd10;
    localparam logic [4:0] ALU_BEQ    = 5'd11;
    localparam logic [4:0] ALU_BNE    = 5'd12;
    localparam logic [4:0] ALU_BLT    = 5'd13;
    localparam logic [4:0] ALU_BGE    = 5'd14;
    localparam logic [4:0] ALU_BLTU   = 5'd15;
    localparam logic [4:0] ALU_BGEU   = 5'd16;
    localparam logic [4:0] ALU_MUL    = 5'd17;
    localparam logic [4:0] ALU_MULH   = 5'd18;
    localparam logic [4:0] ALU_MULHSU = 5'd19;
    localparam logic [4:0] ALU_MULHU  = 5'd20;
    localparam logic [4:0] ALU_DIV    = 5'd21;
    localparam logic [4:0] ALU_DIVU   = 5'd22;
    localparam logic [4:0] ALU_REM    = 5'd23;
    localparam logic [4:0] ALU_REMU   = 5'd24;

    localparam logic       A_RS1 = 1'b0;
    localparam logic       A_PC  = 1'b1;

    localparam logic [1:0] B_RS2  = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;
    localparam logic [1:0] B_FOUR = 2'b10;

    localparam logic [1:0] RD_NONE    = 2'b00;
    localparam logic [1:0] RD_PC_IMM  = 2'b01;
    localparam logic [1:0] RD_RS1_IMM = 2'b10;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    function automatic logic is_cmp(input logic [4:0] op);
        return (op >= ALU_BEQ) && (op <= ALU_BGEU);
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return (op >= ALU_DIV) && (op <= ALU_REMU);
    endfunction

    // MEM is the younger producer, so it wins over WB; x0 never forwards.
    function automatic logic [XLEN-1:0] forward_sel(
        input logic [4:0]      idx,
        input logic [XLEN-1:0] id_data,
        input logic            mem_we,
        input logic [4:0]      mem_rd,
        input logic [XLEN-1:0] mem_val,
        input logic            wb_we,
        input logic [4:0]      wb_rd,
        input logic [XLEN-1:0] wb_val
    );
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == idx)) return mem_val;
        if (wb_we && (wb_rd != 5'd0) && (wb_rd == idx))    return wb_val;
        return id_data;
    endfunction

endpackage

// File: rtl/ex_stage_div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per
// cycle, with divide-by-zero and signed overflow resolved without iterating.
module div_unit
    import ex_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            sign_op,
    input  logic            rem_sel,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    div_state_t      state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            rem_sel_q, rem_sel_d;

    logic            neg_a, neg_b, ovf, div_zero;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] q_fix, r_fix;

    assign neg_a    = sign_op & a[XLEN-1];
    assign neg_b    = sign_op & b[XLEN-1];
    assign mag_a    = neg_a ? (~a + 32'd1) : a;
    assign mag_b    = neg_b ? (~b + 32'd1) : b;
    assign div_zero = (b == 32'd0);
    assign ovf      = sign_op && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // The quotient register doubles as the dividend shifter.
    assign rem_sh = {rem_q, quo_q[XLEN-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};
    assign q_fix  = q_neg_q ? (~quo_q + 32'd1) : quo_q;
    assign r_fix  = r_neg_q ? (~rem_q + 32'd1) : rem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            rem_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            rem_sel_q <= rem_sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: if (start) state_d = (div_zero || ovf) ? DIV_DONE : DIV_RUN;
                DIV_RUN:  if (cnt_q == 6'd31) state_d = DIV_DONE;
                DIV_DONE: state_d = DIV_IDLE;
                default:  state_d = DIV_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        rem_sel_d = rem_sel_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        cnt_d     = '0;
                        dvs_d     = mag_b;
                        rem_sel_d = rem_sel;
                        // Corner cases load final values and skip the sign fix.
                        if (div_zero) begin
                            quo_d   = 32'hFFFF_FFFF;
                            rem_d   = a;
                            q_neg_d = 1'b0;
                            r_neg_d = 1'b0;
                        end else if (ovf) begin
                            quo_d   = 32'h8000_0000;
                            rem_d   = '0;
                            q_neg_d = 1'b0;
                            r_neg_d = 1'b0;
                        end else begin
                            quo_d   = mag_a;
                            rem_d   = '0;
                            q_neg_d = neg_a ^ neg_b;
                            r_neg_d = neg_a;
                        end
                    end
                end
                DIV_RUN: begin
                    cnt_d = cnt_q + 6'd1;
                    if (!diff[XLEN]) begin
                        rem_d = diff[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy   = (state_q != DIV_DONE);
        done   = (state_q == DIV_DONE);
        result = '0;
        if (state_q == DIV_DONE) result = rem_sel_q ? r_fix : q_fix;
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU/compare/multiply, jump and branch
// redirect, and the hand-off to the iterative divider with its stall request.
module ex_stage
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [4:0]  ex_aluc,
    input  logic        ex_rs1Data_EX_PC,
    input  logic [1:0]  ex_rs2Data_EX_imm32_4,
    input  logic [1:0]  ex_pcImm_NEXTPC_rs1Imm,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_rs1Data,
    input  logic [31:0] ex_rs2Data,
    input  logic [31:0] ex_imm32,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic [4:0]  mem_rd,
    input  logic [4:0]  wb_rd,
    input  logic        mem_writeReg,
    input  logic        wb_writeReg,
    input  logic [31:0] mem_aluOut,
    input  logic [31:0] wb_data,
    output logic [31:0] alu_out,
    output logic [31:0] store_data,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        stall_req
);

    logic [31:0] rs1_fwd, rs2_fwd, op_a, op_b;
    logic        cmp_true;
    logic        mul_a_signed, mul_b_signed;
    logic [63:0] mul_a64, mul_b64, prod;
    logic        div_op, div_busy, div_done;
    logic [31:0] div_result;

    assign rs1_fwd = forward_sel(ex_rs1, ex_rs1Data, mem_writeReg, mem_rd, mem_aluOut,
                                 wb_writeReg, wb_rd, wb_data);
    assign rs2_fwd = forward_sel(ex_rs2, ex_rs2Data, mem_writeReg, mem_rd, mem_aluOut,
                                 wb_writeReg, wb_rd, wb_data);
    assign store_data = rs2_fwd;

    assign op_a = (ex_rs1Data_EX_PC == A_PC) ? ex_pc : rs1_fwd;

    always_comb begin
        case (ex_rs2Data_EX_imm32_4)
            B_IMM:   op_b = ex_imm32;
            B_FOUR:  op_b = 32'd4;
            default: op_b = rs2_fwd;
        endcase
    end

    always_comb begin
        case (ex_aluc)
            ALU_BEQ:  cmp_true = (op_a == op_b);
            ALU_BNE:  cmp_true = (op_a != op_b);
            ALU_BLT:  cmp_true = ($signed(op_a) < $signed(op_b));
            ALU_BGE:  cmp_true = ($signed(op_a) >= $signed(op_b));
            ALU_BLTU: cmp_true = (op_a < op_b);
            ALU_BGEU: cmp_true = (op_a >= op_b);
            default:  cmp_true = 1'b0;
        endcase
    end

    // One 64x64 multiplier serves all four variants via operand extension.
    assign mul_a_signed = (ex_aluc == ALU_MULH) || (ex_aluc == ALU_MULHSU);
    assign mul_b_signed = (ex_aluc == ALU_MULH);
    assign mul_a64      = {{32{mul_a_signed & op_a[31]}}, op_a};
    assign mul_b64      = {{32{mul_b_signed & op_b[31]}}, op_b};
    assign prod         = mul_a64 * mul_b64;

    always_comb begin
        case (ex_aluc)
            ALU_SUB:   alu_out = op_a - op_b;
            ALU_SLL:   alu_out = op_a << op_b[4:0];
            ALU_SLT:   alu_out = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:  alu_out = {31'd0, op_a < op_b};
            ALU_XOR:   alu_out = op_a ^ op_b;
            ALU_SRL:   alu_out = op_a >> op_b[4:0];
            ALU_SRA:   alu_out = $signed(op_a) >>> op_b[4:0];
            ALU_OR:    alu_out = op_a | op_b;
            ALU_AND:   alu_out = op_a & op_b;
            ALU_PASSB: alu_out = op_b;
            ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU:
                       alu_out = {31'd0, cmp_true};
            ALU_MUL:   alu_out = prod[31:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:
                       alu_out = prod[63:32];
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU:
                       alu_out = div_result;
            default:   alu_out = op_a + op_b;
        endcase
    end

    always_comb begin
        redirect    = 1'b0;
        redirect_pc = ex_pc + ex_imm32;
        case (ex_pcImm_NEXTPC_rs1Imm)
            RD_PC_IMM:  redirect = is_cmp(ex_aluc) ? cmp_true : 1'b1;
            RD_RS1_IMM: begin
                redirect    = 1'b1;
                redirect_pc = (rs1_fwd + ex_imm32) & ~32'd1;
            end
            default: ;
        endcase
    end

    assign div_op = is_div(ex_aluc);

    div_unit u_div (
        .clk     (clk),
        .rst     (rst),
        .start   (div_op),
        .a       (rs1_fwd),
        .b       (rs2_fwd),
        .sign_op ((ex_aluc == ALU_DIV) || (ex_aluc == ALU_REM)),
        .rem_sel ((ex_aluc == ALU_REM) || (ex_aluc == ALU_REMU)),
        .flush   (flush),
        .busy    (div_busy),
        .done    (div_done),
        .result  (div_result)
    );

    // Flush kills the stall combinationally so the bubble can leave this cycle.
    assign stall_req = div_op && div_busy && !div_done && !flush;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized and directed check of ex_stage against a behavioural model, with
// a scoreboard queue drained by a monitor whenever the stage advances.
`timescale 1ns/1ps
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [4:0]  ex_aluc;
    logic        ex_rs1Data_EX_PC;
    logic [1:0]  ex_rs2Data_EX_imm32_4;
    logic [1:0]  ex_pcImm_NEXTPC_rs1Imm;
    logic [31:0] ex_pc, ex_rs1Data, ex_rs2Data, ex_imm32;
    logic [4:0]  ex_rs1, ex_rs2, mem_rd, wb_rd;
    logic        mem_writeReg, wb_writeReg;
    logic [31:0] mem_aluOut, wb_data;
    logic [31:0] alu_out, store_data, redirect_pc;
    logic        redirect, stall_req;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk                   (clk),
        .rst                   (rst),
        .flush                 (flush),
        .ex_aluc               (ex_aluc),
        .ex_rs1Data_EX_PC      (ex_rs1Data_EX_PC),
        .ex_rs2Data_EX_imm32_4 (ex_rs2Data_EX_imm32_4),
        .ex_pcImm_NEXTPC_rs1Imm(ex_pcImm_NEXTPC_rs1Imm),
        .ex_pc                 (ex_pc),
        .ex_rs1Data            (ex_rs1Data),
        .ex_rs2Data            (ex_rs2Data),
        .ex_imm32              (ex_imm32),
        .ex_rs1                (ex_rs1),
        .ex_rs2                (ex_rs2),
        .mem_rd                (mem_rd),
        .wb_rd                 (wb_rd),
        .mem_writeReg          (mem_writeReg),
        .wb_writeReg           (wb_writeReg),
        .mem_aluOut            (mem_aluOut),
        .wb_data               (wb_data),
        .alu_out               (alu_out),
        .store_data            (store_data),
        .redirect              (redirect),
        .redirect_pc           (redirect_pc),
        .stall_req             (stall_req)
    );

    typedef struct {
        logic [4:0]  aluc;
        logic        asel;
        logic [1:0]  bsel, rsel;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, mem_rd, wb_rd;
        logic        mem_we, wb_we;
        logic [31:0] mem_out, wb_d;
    } stim_t;

    typedef struct {
        logic [31:0] alu, rpc, store;
        logic        redir;
        int          stalls;
        logic        side;
        string       name;
    } exp_t;

    exp_t  sb_q[$];
    exp_t  mon_e;
    int    errors = 0;
    int    checks = 0;
    int    issued = 0;
    int    retired = 0;
    int    stall_cnt = 0;
    logic  tb_valid = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] d, input stim_t s);
        if (s.mem_we && s.mem_rd != 0 && s.mem_rd == idx) return s.mem_out;
        if (s.wb_we && s.wb_rd != 0 && s.wb_rd == idx) return s.wb_d;
        return d;
    endfunction

    function automatic exp_t model(input stim_t s);
        exp_t        e;
        logic [31:0] r1, r2, a, b, res;
        logic [63:0] pu;
        longint      ps;
        logic        cond, is_br, ovf;
        int          op;
        op    = int'(s.aluc);
        r1    = fwd(s.rs1, s.rs1d, s);
        r2    = fwd(s.rs2, s.rs2d, s);
        a     = s.asel ? s.pc : r1;
        b     = (s.bsel == 2'd1) ? s.imm : (s.bsel == 2'd2) ? 32'd4 : r2;
        is_br = (op >= 11) && (op <= 16);
        case (op)
            11: cond = (a == b);
            12: cond = (a != b);
            13: cond = (int'(a) < int'(b));
            14: cond = (int'(a) >= int'(b));
            15: cond = (a < b);
            16: cond = (a >= b);
            default: cond = 1'b0;
        endcase
        ovf      = (op == 21 || op == 23) && r1 == 32'h8000_0000 && r2 == 32'hFFFF_FFFF;
        e.side   = 1'b1;
        e.stalls = 0;
        e.name   = "";
        case (op)
            1:  res = a - b;
            2:  res = a << b[4:0];
            3:  res = {31'd0, int'(a) < int'(b)};
            4:  res = {31'd0, a < b};
            5:  res = a ^ b;
            6:  res = a >> b[4:0];
            7:  res = 32'(int'(a) >>> b[4:0]);
            8:  res = a | b;
            9:  res = a & b;
            10: res = b;
            11, 12, 13, 14, 15, 16: res = {31'd0, cond};
            17: res = a * b;
            18: begin ps = longint'(int'(a)) * longint'(int'(b)); res = ps[63:32]; end
            19: begin ps = longint'(int'(a)) * longint'({32'd0, b}); res = ps[63:32]; end
            20: begin pu = {32'd0, a} * {32'd0, b}; res = pu[63:32]; end
            21: res = (r2 == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(int'(r1) / int'(r2));
            22: res = (r2 == 0) ? 32'hFFFF_FFFF : r1 / r2;
            23: res = (r2 == 0) ? r1 : ovf ? 32'd0 : 32'(int'(r1) % int'(r2));
            24: res = (r2 == 0) ? r1 : r1 % r2;
            default: res = a + b;
        endcase
        if (op >= 21 && op <= 24) begin
            e.side   = 1'b0;
            e.stalls = (r2 == 0 || ovf) ? 1 : 33;
        end
        e.alu   = res;
        e.store = r2;
        e.redir = 1'b0;
        e.rpc   = 32'd0;
        if (s.rsel == 2'd1) begin
            e.redir = is_br ? cond : 1'b1;
            e.rpc   = s.pc + s.imm;
        end else if (s.rsel == 2'd2) begin
            e.redir = 1'b1;
            e.rpc   = (r1 + s.imm) & 32'hFFFF_FFFE;
        end
        return e;
    endfunction

    function automatic stim_t blank();
        stim_t s;
        s.aluc = 0; s.asel = 0; s.bsel = 0; s.rsel = 0;
        s.pc = 0; s.rs1d = 0; s.rs2d = 0; s.imm = 0;
        s.rs1 = 0; s.rs2 = 0; s.mem_rd = 0; s.wb_rd = 0;
        s.mem_we = 0; s.wb_we = 0; s.mem_out = 0; s.wb_d = 0;
        return s;
    endfunction

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.aluc    = 5'($urandom_range(0, 31));
        s.asel    = 1'($urandom_range(0, 1));
        s.bsel    = 2'($urandom_range(0, 2));
        s.rsel    = 2'($urandom_range(0, 2));
        s.pc      = $urandom & 32'hFFFF_FFFC;
        s.rs1d    = rand_data();
        s.rs2d    = rand_data();
        s.imm     = rand_data();
        s.rs1     = 5'($urandom_range(0, 3));
        s.rs2     = 5'($urandom_range(0, 3));
        s.mem_rd  = 5'($urandom_range(0, 3));
        s.wb_rd   = 5'($urandom_range(0, 3));
        s.mem_we  = 1'($urandom_range(0, 1));
        s.wb_we   = 1'($urandom_range(0, 1));
        s.mem_out = rand_data();
        s.wb_d    = rand_data();
        return s;
    endfunction

    task automatic apply(input stim_t s);
        ex_aluc = s.aluc; ex_rs1Data_EX_PC = s.asel;
        ex_rs2Data_EX_imm32_4 = s.bsel; ex_pcImm_NEXTPC_rs1Imm = s.rsel;
        ex_pc = s.pc; ex_rs1Data = s.rs1d; ex_rs2Data = s.rs2d; ex_imm32 = s.imm;
        ex_rs1 = s.rs1; ex_rs2 = s.rs2; mem_rd = s.mem_rd; wb_rd = s.wb_rd;
        mem_writeReg = s.mem_we; wb_writeReg = s.wb_we;
        mem_aluOut = s.mem_out; wb_data = s.wb_d;
    endtask

    // Drives one ID/EX instruction and holds it until the monitor retires it.
    // With scramble set, MEM/WB keep changing during the stall.
    task automatic issue(input string nm, input stim_t s, input logic scramble);
        exp_t e;
        int   n;
        e      = model(s);
        e.name = nm;
        sb_q.push_back(e);
        apply(s);
        issued++;
        tb_valid = 1'b1;
        n = 0;
        while (retired != issued && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (scramble && retired != issued) begin
                mem_aluOut = $urandom; wb_data = $urandom;
                mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
                mem_writeReg = 1'($urandom_range(0, 1)); wb_writeReg = 1'($urandom_range(0, 1));
            end
        end
        if (retired != issued) begin
            errors++;
            checks++;
            $display("FAIL %s timeout: not retired after %0d cycles, expected within 35", nm, n);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1, "stage never advanced");
        end
    endtask

    always @(negedge clk) begin
        if (!rst && tb_valid && retired != issued) begin
            if (stall_req) begin
                stall_cnt++;
            end else begin
                if (sb_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL sb_empty: output retired with no expected entry, got 0x%08h", alu_out);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk({mon_e.name, " alu_out"}, alu_out, mon_e.alu);
                    chk({mon_e.name, " stall_cycles"}, 32'(stall_cnt), 32'(mon_e.stalls));
                    if (mon_e.side) begin
                        chk({mon_e.name, " redirect"}, {31'd0, redirect}, {31'd0, mon_e.redir});
                        if (mon_e.redir) chk({mon_e.name, " redirect_pc"}, redirect_pc, mon_e.rpc);
                        chk({mon_e.name, " store_data"}, store_data, mon_e.store);
                    end
                end
                stall_cnt = 0;
                retired++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, " alu_out"}, alu_out, 32'd0);
        chk({tag, " redirect"}, {31'd0, redirect}, 32'd0);
        chk({tag, " redirect_pc"}, redirect_pc, 32'd0);
        chk({tag, " store_data"}, store_data, 32'd0);
        chk({tag, " stall_req"}, {31'd0, stall_req}, 32'd0);
    endtask

    initial begin
        stim_t s;
        rst   = 1'b1;
        flush = 1'b0;
        apply(blank());
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        s = blank(); s.bsel = 1; s.imm = 1; s.rs1 = 5; s.rs1d = 32'h1234;
        s.mem_rd = 5; s.wb_rd = 5; s.mem_we = 1; s.wb_we = 1; s.mem_out = 7; s.wb_d = 9;
        issue("fwd_mem_over_wb", s, 0);

        s = blank(); s.bsel = 1; s.imm = 1; s.rs1 = 0; s.rs1d = 32'h10;
        s.wb_rd = 0; s.wb_we = 1; s.wb_d = 32'h55;
        issue("fwd_wb_rd0", s, 0);

        s = blank(); s.aluc = 1; s.rs1 = 2; s.rs1d = 100; s.rs2 = 3; s.rs2d = 5;
        s.mem_rd = 3; s.mem_we = 0; s.mem_out = 77; s.wb_rd = 3; s.wb_we = 1; s.wb_d = 30;
        issue("fwd_wb_only", s, 0);

        s = blank(); s.aluc = 13; s.rs1d = 32'hFFFF_FFFF; s.rs2d = 1;
        s.rsel = 1; s.pc = 32'h100; s.imm = 32'h20;
        issue("blt_taken", s, 0);
        s.aluc = 15;
        issue("bltu_not_taken", s, 0);

        s = blank(); s.asel = 1; s.bsel = 2; s.rsel = 2; s.pc = 32'h400;
        s.rs1d = 32'h203; s.imm = 4;
        issue("jalr", s, 0);

        s = blank(); s.aluc = 21; s.rs1 = 6; s.mem_rd = 6; s.mem_we = 1;
        s.mem_out = 32'hFFFF_FFF9; s.rs2 = 7; s.rs2d = 2;
        issue("div_neg7_2", s, 1);
        s.aluc = 23;
        issue("rem_neg7_2", s, 1);

        s = blank(); s.aluc = 22; s.rs1d = 1234; s.rs2d = 0;
        issue("divu_by_zero", s, 0);

        s = blank(); s.aluc = 21; s.rs1d = 32'h8000_0000; s.rs2d = 32'hFFFF_FFFF;
        issue("div_overflow", s, 0);
        s.aluc = 23;
        issue("rem_overflow", s, 0);

        s = blank(); s.aluc = 22; s.rs1d = 1000; s.rs2d = 7;
        issue("divu_b2b_1", s, 0);
        s.aluc = 24;
        issue("remu_b2b_2", s, 0);

        // Flush in the middle of an iteration.
        s = blank(); s.aluc = 21; s.rs1d = 100; s.rs2d = 3;
        apply(s);
        tb_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("flush_pre stall_req", {31'd0, stall_req}, 32'd1);
        flush = 1'b1;
        #1;
        chk("flush stall_req", {31'd0, stall_req}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        issue("div_after_flush", s, 0);

        // Asynchronous reset in the middle of an iteration.
        s = blank(); s.aluc = 24; s.rs1d = 32'hDEAD_BEEF; s.rs2d = 13;
        apply(s);
        tb_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        apply(blank());
        #1;
        check_reset_outputs("mid_run_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        issue("remu_after_reset", s, 0);

        for (int i = 0; i < 300; i++) begin
            s = rand_stim();
            issue($sformatf("rand%0d_op%0d", i, s.aluc), s, 1);
        end

        tb_valid = 1'b0;
        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
